// File: rtl/board_draw_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : display_defs                                             |
// | Purpose   : Shared display constants and draw-sequencer state        |
// |             encodings for the minesweeper board renderer.            |
// | Contents  : CELL_PX, VGA_W, VGA_H, WHITE, BLACK, draw_state_t        |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package display_defs;

   localparam int CELL_PX = 8;     // cell edge length in pixels
   localparam int VGA_W   = 160;   // adapter resolution, x
   localparam int VGA_H   = 120;   // adapter resolution, y

   localparam logic [2:0] WHITE = 3'b111;
   localparam logic [2:0] BLACK = 3'b000;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BOARD = 2'd1,
      ST_CELL  = 2'd2,
      ST_FIN   = 2'd3
   } draw_state_t;

endpackage
`default_nettype wire

// File: rtl/board_draw_ctrl_box_raster.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : box_raster                                               |
// | Purpose   : Row-major pixel walker over one CELL_PX x CELL_PX box.   |
// |             px is the inner (fast) index, py the outer one.          |
// | Ports     : clock, resetn   - clock / async active-low reset         |
// |             clear           - return to pixel (0,0)                  |
// |             step            - advance one pixel (wraps after last)   |
// |             px, py          - current pixel within the box           |
// |             last_pixel      - current pixel is (7,7)                 |
// |             is_border       - current pixel lies on the box outline  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module box_raster
   import display_defs::*;
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       clear,
   input  logic       step,
   output logic [2:0] px,
   output logic [2:0] py,
   output logic       last_pixel,
   output logic       is_border
);

   localparam logic [2:0] c_last_px = 3'(CELL_PX - 1);

   logic [2:0] r_px;
   logic [2:0] r_py;

   // Stepping past the last pixel wraps both counters to zero, so the
   // next box starts on the very next step with no idle cycle.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_px <= 3'd0;
         r_py <= 3'd0;
      end else if (clear) begin
         r_px <= 3'd0;
         r_py <= 3'd0;
      end else if (step) begin
         r_px <= (r_px == c_last_px) ? 3'd0 : r_px + 3'd1;
         if (r_px == c_last_px) begin
            r_py <= (r_py == c_last_px) ? 3'd0 : r_py + 3'd1;
         end
      end
   end

   assign px         = r_px;
   assign py         = r_py;
   assign last_pixel = (r_px == c_last_px) && (r_py == c_last_px);
   assign is_border  = (r_px == 3'd0) || (r_px == c_last_px) ||
                       (r_py == 3'd0) || (r_py == c_last_px);

endmodule
`default_nettype wire

// File: rtl/board_draw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : board_draw_ctrl                                          |
// | Purpose   : Owns the VGA adapter write port. Draws the full empty    |
// |             board (GRID_SIZE x GRID_SIZE outlined boxes) or redraws  |
// |             a single cell, one pixel per clock.                      |
// | Ports     : clock, resetn        - clock / async active-low reset    |
// |             start_board          - full-board draw request (level)   |
// |             cell_req             - single-cell redraw request (level)|
// |             cell_row, cell_col   - cell address for cell_req         |
// |             cell_colour          - interior colour for cell_req      |
// |             board_ack, cell_ack  - one-cycle acceptance pulses       |
// |             busy                 - job in progress                   |
// |             done                 - one-cycle end-of-job pulse        |
// |             x, y, colour,writeEn - VGA adapter pixel write port      |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module board_draw_ctrl
   import display_defs::*;
#(
   parameter int         GRID_SIZE   = 8,
   parameter int         CELL_PX     = 8,
   parameter int         ORIGIN_X    = 16,
   parameter int         ORIGIN_Y    = 8,
   parameter logic [2:0] LINE_COLOUR = WHITE,
   parameter logic [2:0] FILL_COLOUR = BLACK
)
(
   input  logic       clock,
   input  logic       resetn,
   input  logic       start_board,
   input  logic       cell_req,
   input  logic [3:0] cell_row,
   input  logic [3:0] cell_col,
   input  logic [2:0] cell_colour,
   output logic       board_ack,
   output logic       cell_ack,
   output logic       busy,
   output logic       done,
   output logic [7:0] x,
   output logic [6:0] y,
   output logic [2:0] colour,
   output logic       writeEn
);

   // ------------------------------------------------------------------
   // Elaboration-time sanity checks on the board geometry
   // ------------------------------------------------------------------
   if (GRID_SIZE < 1 || GRID_SIZE > 15) begin : g_bad_grid
      $error("board_draw_ctrl: GRID_SIZE must be 1..15");
   end
   if (CELL_PX != 8) begin : g_bad_cell_px
      $error("board_draw_ctrl: CELL_PX must be 8");
   end
   if (ORIGIN_X + GRID_SIZE * CELL_PX > VGA_W) begin : g_bad_origin_x
      $error("board_draw_ctrl: board exceeds screen width");
   end
   if (ORIGIN_Y + GRID_SIZE * CELL_PX > VGA_H) begin : g_bad_origin_y
      $error("board_draw_ctrl: board exceeds screen height");
   end

   localparam logic [3:0] c_last_idx = 4'(GRID_SIZE - 1);
   localparam logic [3:0] c_grid     = 4'(GRID_SIZE);

   // ------------------------------------------------------------------
   // Registers and next-state wires
   // ------------------------------------------------------------------
   draw_state_t r_state, w_state_nxt;

   logic [7:0] r_x,         w_x_nxt;
   logic [6:0] r_y,         w_y_nxt;
   logic [2:0] r_colour,    w_colour_nxt;
   logic       r_we,        w_we_nxt;
   logic       r_busy,      w_busy_nxt;
   logic       r_done,      w_done_nxt;
   logic       r_board_ack, w_board_ack_nxt;
   logic       r_cell_ack,  w_cell_ack_nxt;
   logic [3:0] r_row,       w_row_nxt;
   logic [3:0] r_col,       w_col_nxt;
   logic [2:0] r_interior,  w_interior_nxt;

   logic       w_clear;
   logic       w_step;
   logic [2:0] w_px;
   logic [2:0] w_py;
   logic       w_last_pixel;
   logic       w_is_border;
   logic       w_cell_in_range;
   logic [7:0] w_pix_x;
   logic [6:0] w_pix_y;

   box_raster u_box_raster (
      .clock      (clock),
      .resetn     (resetn),
      .clear      (w_clear),
      .step       (w_step),
      .px         (w_px),
      .py         (w_py),
      .last_pixel (w_last_pixel),
      .is_border  (w_is_border)
   );

   // Screen coordinates are formed at full width and then truncated to
   // the adapter port widths; the geometry checks above keep them in range.
   assign w_pix_x = 8'(9'(ORIGIN_X) + 9'({r_col, 3'b000}) + 9'(w_px));
   assign w_pix_y = 7'(8'(ORIGIN_Y) + 8'({r_row, 3'b000}) + 8'(w_py));

   assign w_cell_in_range = (cell_row < c_grid) && (cell_col < c_grid);

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_colour_nxt    = r_colour;
      w_we_nxt        = 1'b0;
      w_busy_nxt      = r_busy;
      w_done_nxt      = 1'b0;
      w_board_ack_nxt = 1'b0;
      w_cell_ack_nxt  = 1'b0;
      w_row_nxt       = r_row;
      w_col_nxt       = r_col;
      w_interior_nxt  = r_interior;
      w_clear         = 1'b0;
      w_step          = 1'b0;

      case (r_state)
         ST_IDLE: begin
            // Board init wins when both requesters are waiting; the cell
            // requester keeps its level high and is served afterwards.
            if (start_board) begin
               w_board_ack_nxt = 1'b1;
               w_busy_nxt      = 1'b1;
               w_clear         = 1'b1;
               w_row_nxt       = 4'd0;
               w_col_nxt       = 4'd0;
               w_interior_nxt  = FILL_COLOUR;
               w_state_nxt     = ST_BOARD;
            end else if (cell_req) begin
               w_cell_ack_nxt  = 1'b1;
               w_busy_nxt      = 1'b1;
               w_clear         = 1'b1;
               w_row_nxt       = cell_row;
               w_col_nxt       = cell_col;
               w_interior_nxt  = cell_colour;
               // An off-board cell is acknowledged but draws nothing.
               w_state_nxt     = w_cell_in_range ? ST_CELL : ST_FIN;
            end
         end

         ST_BOARD, ST_CELL: begin
            w_we_nxt     = 1'b1;
            w_x_nxt      = w_pix_x;
            w_y_nxt      = w_pix_y;
            w_colour_nxt = w_is_border ? LINE_COLOUR : r_interior;
            w_step       = 1'b1;
            if (w_last_pixel) begin
               if (r_state == ST_CELL) begin
                  w_state_nxt = ST_FIN;
               end else if (r_col == c_last_idx) begin
                  w_col_nxt = 4'd0;
                  if (r_row == c_last_idx) begin
                     w_state_nxt = ST_FIN;
                  end else begin
                     w_row_nxt = r_row + 4'd1;
                  end
               end else begin
                  w_col_nxt = r_col + 4'd1;
               end
            end
         end

         ST_FIN: begin
            w_done_nxt  = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Output and job-context registers
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_x         <= 8'd0;
         r_y         <= 7'd0;
         r_colour    <= 3'd0;
         r_we        <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_board_ack <= 1'b0;
         r_cell_ack  <= 1'b0;
         r_row       <= 4'd0;
         r_col       <= 4'd0;
         r_interior  <= 3'd0;
      end else begin
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_colour    <= w_colour_nxt;
         r_we        <= w_we_nxt;
         r_busy      <= w_busy_nxt;
         r_done      <= w_done_nxt;
         r_board_ack <= w_board_ack_nxt;
         r_cell_ack  <= w_cell_ack_nxt;
         r_row       <= w_row_nxt;
         r_col       <= w_col_nxt;
         r_interior  <= w_interior_nxt;
      end
   end

   assign x         = r_x;
   assign y         = r_y;
   assign colour    = r_colour;
   assign writeEn   = r_we;
   assign busy      = r_busy;
   assign done      = r_done;
   assign board_ack = r_board_ack;
   assign cell_ack  = r_cell_ack;

endmodule
`default_nettype wire

// File: tb/tb_board_draw_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_board_draw_ctrl                                       |
// | Purpose   : Self-checking bench for board_draw_ctrl, GRID_SIZE=2,    |
// |             origin (16,8). Pixel writes are collected into a frame   |
// |             buffer and checked against a hand-computed pixel table.  |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module tb_board_draw_ctrl;

   logic       clock = 1'b0;
   logic       resetn;
   logic       start_board;
   logic       cell_req;
   logic [3:0] cell_row;
   logic [3:0] cell_col;
   logic [2:0] cell_colour;
   logic       board_ack;
   logic       cell_ack;
   logic       busy;
   logic       done;
   logic [7:0] x;
   logic [6:0] y;
   logic [2:0] colour;
   logic       writeEn;

   always #5 clock = ~clock;

   board_draw_ctrl #(
      .GRID_SIZE   (2),
      .CELL_PX     (8),
      .ORIGIN_X    (16),
      .ORIGIN_Y    (8),
      .LINE_COLOUR (3'b111),
      .FILL_COLOUR (3'b000)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .start_board (start_board),
      .cell_req    (cell_req),
      .cell_row    (cell_row),
      .cell_col    (cell_col),
      .cell_colour (cell_colour),
      .board_ack   (board_ack),
      .cell_ack    (cell_ack),
      .busy        (busy),
      .done        (done),
      .x           (x),
      .y           (y),
      .colour      (colour),
      .writeEn     (writeEn)
   );

   // Frame buffer: 4'hF marks a pixel never written.
   logic [3:0] fb [0:159][0:119];

   typedef struct {
      int         phase;   // 0: after board draw, 1: after cell (1,0) redraw
      int         px;
      int         py;
      logic [3:0] exp;
   } pix_vec_t;

   pix_vec_t vecs [16];

   int n_tests = 0;
   int n_fail  = 0;

   // Per-job observation record, indices relative to the ack cycle (0).
   int we_cnt, first_we, last_we, done_at;
   int first_x, first_y, last_x, last_y, w64_x, w64_y;
   int min_x, max_x, min_y, max_y;
   int cell_ack_seen, board_ack_seen;
   logic busy_at_done, we_at_done;
   bit got_done;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic clear_fb();
      for (int i = 0; i < 160; i++)
         for (int j = 0; j < 120; j++)
            fb[i][j] = 4'hF;
   endtask

   // Called at the ack negedge; steps negedges until done or budget.
   task automatic observe(input int budget);
      we_cnt = 0; first_we = -1; last_we = -1; done_at = -1;
      first_x = -1; first_y = -1; last_x = -1; last_y = -1; w64_x = -1; w64_y = -1;
      min_x = 999; max_x = -1; min_y = 999; max_y = -1;
      cell_ack_seen = 0; board_ack_seen = 0;
      busy_at_done = 1'bx; we_at_done = 1'bx;
      got_done = 1'b0;
      for (int i = 1; i <= budget && !got_done; i++) begin
         @(negedge clock);
         if (writeEn) begin
            if (first_we < 0) begin first_we = i; first_x = int'(x); first_y = int'(y); end
            if (we_cnt == 64) begin w64_x = int'(x); w64_y = int'(y); end
            last_we = i; last_x = int'(x); last_y = int'(y);
            we_cnt++;
            if (int'(x) < min_x) min_x = int'(x);
            if (int'(x) > max_x) max_x = int'(x);
            if (int'(y) < min_y) min_y = int'(y);
            if (int'(y) > max_y) max_y = int'(y);
            if (x < 8'd160 && y < 7'd120) fb[x][y] = {1'b0, colour};
         end
         if (cell_ack)  cell_ack_seen++;
         if (board_ack) board_ack_seen++;
         if (done) begin
            got_done     = 1'b1;
            done_at      = i;
            busy_at_done = busy;
            we_at_done   = writeEn;
         end
      end
      if (!got_done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_table(input int phase);
      for (int i = 0; i < 16; i++) begin
         if (vecs[i].phase == phase)
            check($sformatf("pix(%0d,%0d)", vecs[i].px, vecs[i].py),
                  32'(fb[vecs[i].px][vecs[i].py]), 32'(vecs[i].exp));
      end
   endtask

   int cnt_done, cnt_we, cnt_ack;

   initial begin
      vecs[0]  = '{0, 16,  8, 4'h7};   // first pixel, corner
      vecs[1]  = '{0, 17,  9, 4'h0};   // interior of cell (0,0)
      vecs[2]  = '{0, 31, 23, 4'h7};   // last pixel, corner
      vecs[3]  = '{0, 23,  8, 4'h7};   // right edge of cell (0,0)
      vecs[4]  = '{0, 24,  8, 4'h7};   // left edge of cell (0,1)
      vecs[5]  = '{0, 20, 12, 4'h0};
      vecs[6]  = '{0, 28, 20, 4'h0};   // interior of cell (1,1)
      vecs[7]  = '{0, 30, 22, 4'h0};
      vecs[8]  = '{0, 32,  8, 4'hF};   // just right of the board
      vecs[9]  = '{1, 19, 19, 4'h4};   // interior of cell (1,0)
      vecs[10] = '{1, 16, 16, 4'h7};
      vecs[11] = '{1, 23, 23, 4'h7};
      vecs[12] = '{1, 20, 16, 4'h7};   // top edge
      vecs[13] = '{1, 17, 22, 4'h4};
      vecs[14] = '{1, 24, 16, 4'hF};   // neighbour cell untouched
      vecs[15] = '{1, 19, 15, 4'hF};   // cell above untouched

      resetn = 1'b0; start_board = 1'b0; cell_req = 1'b0;
      cell_row = 4'd0; cell_col = 4'd0; cell_colour = 3'd0;
      repeat (3) @(negedge clock);
      check("reset_outputs", 32'({x, y, colour, writeEn, busy, done, board_ack, cell_ack}), 32'd0);
      resetn = 1'b1;
      @(negedge clock);

      // ---------------- full board draw ----------------
      clear_fb();
      start_board = 1'b1;
      @(negedge clock);
      check("board_ack", 32'({board_ack, cell_ack, busy, writeEn}), 32'b1010);
      start_board = 1'b0;
      observe(400);
      check("board_we_count", we_cnt, 256);
      check("board_first_we", first_we, 1);
      check("board_contiguous", last_we - first_we + 1, we_cnt);
      check("board_done_at", done_at, 257);
      check("board_done_busy_we", 32'({busy_at_done, we_at_done}), 32'd0);
      check("board_first_xy", 32'({first_x[7:0], first_y[7:0]}), 32'({8'd16, 8'd8}));
      check("board_pix64_xy", 32'({w64_x[7:0], w64_y[7:0]}), 32'({8'd24, 8'd8}));
      check("board_last_xy", 32'({last_x[7:0], last_y[7:0]}), 32'({8'd31, 8'd23}));
      check("board_ack_width", board_ack_seen, 0);
      check_table(0);
      @(negedge clock);
      check("board_done_width", 32'(done), 32'd0);

      // ---------------- single cell (1,0) ----------------
      clear_fb();
      cell_req = 1'b1; cell_row = 4'd1; cell_col = 4'd0; cell_colour = 3'b100;
      @(negedge clock);
      check("cell_ack", 32'({board_ack, cell_ack, busy}), 32'b011);
      cell_req = 1'b0;
      observe(200);
      check("cell_we_count", we_cnt, 64);
      check("cell_contiguous", last_we - first_we + 1, we_cnt);
      check("cell_done_at", done_at, 65);
      check("cell_x_span", 32'({min_x[7:0], max_x[7:0]}), 32'({8'd16, 8'd23}));
      check("cell_y_span", 32'({min_y[7:0], max_y[7:0]}), 32'({8'd16, 8'd23}));
      check_table(1);
      @(negedge clock);

      // ---------------- out-of-range cells ----------------
      for (int k = 0; k < 2; k++) begin
         cell_req = 1'b1;
         cell_row = (k == 0) ? 4'd2 : 4'd0;
         cell_col = (k == 0) ? 4'd0 : 4'd15;
         cell_colour = 3'b010;
         @(negedge clock);
         check($sformatf("oor%0d_ack", k), 32'(cell_ack), 32'd1);
         cell_req = 1'b0;
         observe(10);
         check($sformatf("oor%0d_we_count", k), we_cnt, 0);
         check($sformatf("oor%0d_done_soon", k), 32'(done_at >= 1 && done_at <= 2), 32'd1);
         @(negedge clock);
      end

      // ---------------- simultaneous requests ----------------
      clear_fb();
      start_board = 1'b1;
      cell_req = 1'b1; cell_row = 4'd0; cell_col = 4'd1; cell_colour = 3'b010;
      @(negedge clock);
      check("simul_acks", 32'({board_ack, cell_ack}), 32'b10);
      start_board = 1'b0;
      observe(400);
      check("simul_no_cell_ack_while_busy", cell_ack_seen, 0);
      check("simul_board_we_count", we_cnt, 256);
      check_table(0);
      @(negedge clock);
      check("simul_cell_ack_after_done", 32'({cell_ack, board_ack}), 32'b10);
      cell_req = 1'b0;
      observe(200);
      check("simul_cell_we_count", we_cnt, 64);
      check("simul_cell_x_span", 32'({min_x[7:0], max_x[7:0]}), 32'({8'd24, 8'd31}));
      check("simul_cell_y_span", 32'({min_y[7:0], max_y[7:0]}), 32'({8'd8, 8'd15}));
      check("simul_cell_interior", 32'(fb[27][11]), 32'h2);
      check("simul_cell_border", 32'(fb[24][8]), 32'h7);
      @(negedge clock);

      // ---------------- reset in the middle of a board draw ----------------
      start_board = 1'b1;
      @(negedge clock);
      start_board = 1'b0;
      repeat (39) @(negedge clock);
      check("mid_board_we", 32'({writeEn, busy}), 32'b11);
      #2 resetn = 1'b0;
      #1;
      check("async_reset_outputs", 32'({x, y, colour, writeEn, busy, done, board_ack, cell_ack}), 32'd0);
      repeat (3) @(negedge clock);
      resetn = 1'b1;
      cnt_done = 0; cnt_we = 0; cnt_ack = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (done) cnt_done++;
         if (writeEn) cnt_we++;
         if (board_ack || cell_ack || busy) cnt_ack++;
      end
      check("post_reset_no_done", cnt_done, 0);
      check("post_reset_no_we", cnt_we, 0);
      check("post_reset_idle", cnt_ack, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/board_draw_ctrl.md
Name: board_draw_ctrl

Overview:
Pixel-write sequencer for the minesweeper board display. It draws the whole empty board as a GRID_SIZE x GRID_SIZE array of 8x8 boxes, and it redraws single cells on request. It owns the single VGA adapter write port (x, y, colour, writeEn) and arbitrates between board-init and cell-redraw requesters. The board FSM and the cell-update logic feed it; it drives the VGA adapter directly.

Parameters:
GRID_SIZE, 8, cells per row and per column (1..15).
CELL_PX, 8, cell edge length in pixels (power of two, fixed 8 for this revision).
ORIGIN_X, 16, screen x of the board's top-left pixel.
ORIGIN_Y, 8, screen y of the board's top-left pixel.
LINE_COLOUR, 3'b111, box outline colour.
FILL_COLOUR, 3'b000, interior colour used for board init.

Ports:
clock  in  1  system clock (50 MHz)
resetn  in  1  asynchronous reset, active-low
start_board  in  1  level; request full-board draw, held until ack
cell_req  in  1  level; request single-cell redraw, held until ack
cell_row  in  4  row of requested cell, sampled with cell_req
cell_col  in  4  column of requested cell, sampled with cell_req
cell_colour  in  3  interior colour for requested cell
board_ack  out  1  one-cycle pulse: start_board accepted
cell_ack  out  1  one-cycle pulse: cell_req accepted
busy  out  1  high from acceptance until the done pulse
done  out  1  one-cycle pulse after the last pixel of a job
x  out  8  pixel x to VGA adapter
y  out  7  pixel y to VGA adapter
colour  out  3  pixel colour to VGA adapter
writeEn  out  1  pixel write strobe

Behaviour:
- Reset (resetn low, asynchronous): state IDLE; x=0, y=0, colour=0, writeEn=0, busy=0, done=0, both acks=0; in-flight job abandoned, no resume.
- All outputs registered. States: IDLE, BOARD, CELL, FIN.
- IDLE: start_board has priority over cell_req when both are high. On the accepting edge: matching ack pulses, busy=1, pixel counters cleared, state goes to BOARD or CELL. Request signals are ignored outside IDLE; requesters hold them until acked.
- Box raster: 64 pixels per cell, row-major (px 0..7 inner, py 0..7 outer), one pixel per cycle.
  - Pixel colour is LINE_COLOUR when px or py is 0 or 7, else the interior colour.
  - Interior colour is FILL_COLOUR in BOARD and the latched cell_colour in CELL.
- Coordinates: x = ORIGIN_X + col*8 + px; y = ORIGIN_Y + row*8 + py. Compute 9-bit/8-bit, then truncate. Elaboration constraints: ORIGIN_X + GRID_SIZE*8 <= 160 and ORIGIN_Y + GRID_SIZE*8 <= 120.
- writeEn is high on the first cycle after acceptance and stays high contiguously for the whole job with no gaps between cells.
  - BOARD: GRID_SIZE*GRID_SIZE*64 cycles, cells in row-major order (col inner).
  - CELL: 64 cycles.
- FIN: writeEn=0, done=1 for one cycle, busy=0 on the same edge, then IDLE. A new request can be acked on the cycle after done.
- Out-of-range cell (cell_row or cell_col >= GRID_SIZE): cell_ack pulses, no pixels are written (writeEn stays 0), and the job goes straight to FIN/done.
- Counter wrap: px wraps 7 to 0 and increments py; py wraps and increments col; col wraps and increments row. The last pixel of the last cell moves to FIN.

Decomposition:
- Shared package/header (display_defs): state encodings, CELL_PX, VGA_W=160, VGA_H=120, colour constants (WHITE=3'b111, BLACK=3'b000).
- Sub-module box_raster: given clear/step inputs, produces px, py, last_pixel and is_border. Reused later by the cursor overlay.

Test Plan:
- Reset mid-BOARD (GRID_SIZE=2, resetn low at cycle 40) -> all outputs 0 immediately; IDLE; no done pulse.
- start_board with GRID_SIZE=2, ORIGIN=(16,8) -> board_ack 1 cycle; writeEn high for exactly 256 cycles.
  - First pixel (16,8) is 3'b111; pixel (17,9) is 3'b000; last pixel (31,23) is 3'b111.
  - done pulses 1 cycle later.
- cell_req row=1 col=0 colour=3'b100 -> 64 writes spanning x 16..23, y 16..23; interior pixel (19,19) is 3'b100; border pixels are 3'b111.
- start_board and cell_req raised on the same cycle -> board_ack only; cell_req stays pending; cell_ack comes on the cycle after done.
- cell_req row=2 col=0 with GRID_SIZE=2 -> cell_ack, zero writeEn cycles, done within 2 cycles.
- Requests asserted while busy -> no ack and no output perturbation until IDLE.
